kanagawa_cross_region_arbiter: RTL and testbench
================================================

# kanagawa_cross_region_arbiter

Shares the single write port of one cross-region FIFO among NUM_REQ requesters on the producer side of an export-class boundary. Round-robin arbitration with packet locking; flow control uses credits, not the FIFO's early `full`. Accepted beats are tagged with their source index and passed through a WRITE_DELAY-stage register pipeline to the FIFO write port. The FIFO instance must use a matching WRITE_DELAY.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- WIDTH, 16, payload bits per beat
- DEPTH, 32, FIFO entries; initial credit count
- WRITE_DELAY, 0, extra register stages between arbiter and FIFO write port
- ID_WIDTH, $clog2(NUM_REQ), source-tag width
- CREDIT_WIDTH, $clog2(DEPTH+1), credit counter width

- clock  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low
- req_valid  in  NUM_REQ  beat valid per requester
- req_data  in  NUM_REQ*WIDTH  payload; requester i occupies bits [i*WIDTH +: WIDTH]
- req_last  in  NUM_REQ  final beat of a packet
- req_ready  out  NUM_REQ  beat accepted when valid&ready
- fifo_wrreq  out  1  FIFO write strobe
- fifo_data  out  ID_WIDTH+WIDTH  {source id, payload}
- credit_return  in  1  one pulse per FIFO pop (rdreq & !empty)
- credits  out  CREDIT_WIDTH  free FIFO entries not yet claimed
- overflow_err  out  1  sticky credit-return error

## Operation
- States: IDLE, LOCKED(owner).
- IDLE:
  - Winner = first valid requester at or after rr_ptr (wrapping).
  - req_ready[winner] = credits≠0; all other readies are 0.
  - On an accepted beat with last=0: go to LOCKED(winner).
  - On any accepted beat: rr_ptr ← winner+1 mod NUM_REQ.
- LOCKED(o):
  - Only req_ready[o] may be asserted, = credits≠0; other valids are ignored.
  - On an accepted beat with last=1: go to IDLE. rr_ptr is already o+1.
- At most one accept per cycle.
- Credits:
  - credits_next = credits − accept + credit_return.
  - Accept and return in the same cycle: no change.
  - Return with credits==DEPTH and no accept: counter holds; overflow_err←1. It stays 1 until reset.
  - Accept is impossible at 0 because ready is gated.
- FIFO `full` and `almost_full` are not used. Credits alone guarantee no overflow.

## Timing
- Combinational paths: req_ready depends on req_valid, state, rr_ptr and credits. No other outputs are combinational.
- Latency: a beat accepted in cycle t drives fifo_wrreq/fifo_data in cycle t+1+WRITE_DELAY.
- credits is registered and reflects the accept/return of cycle t in cycle t+1.
- Reset values: req_ready=0, fifo_wrreq=0, fifo_data=0, credits=DEPTH, overflow_err=0. Internal state: state=IDLE, rr_ptr=0, pipeline valids cleared.
- Reset asserted mid-packet: lock is dropped and in-flight pipeline beats are discarded (fifo_wrreq=0 immediately). The FIFO must be reset together with the arbiter.
- Back-to-back: a requester with continuous valid sustains one beat per cycle while locked and credits≠0.

## Structure
- Shared package kanagawa_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, LOCKED}
  - localparam function for ID width, used by both this block and the read-side demux
- Sub-module KanagawaRoundRobinPicker: inputs req vector and rr_ptr; outputs one-hot grant and encoded index. Purely combinational, reusable by the read-side scheduler.
- Delay pipeline: inline generate loop of WRITE_DELAY registers on {wrreq, data}.

## Test plan
All cases: NUM_REQ=4, WIDTH=8, DEPTH=4, WRITE_DELAY=2.
1. Release reset → credits=4, all req_ready=0, fifo_wrreq=0, overflow_err=0.
2. req0 sends 0xA5 with last=1 in cycle t → fifo_wrreq=1 at t+3 with fifo_data={2'd0,8'hA5}; credits=3 at t+1.
3. All four valid single-beat, held → accepts 0,1,2,3 in consecutive cycles. Then credits=0 and all readies 0. One credit_return pulse → req0 accepted in the next cycle, credits back to 0.
4. req1 3-beat packet (last on beat 3) while req2 and req3 are valid → only req1 is ready for 3 cycles. Then req2 is accepted, then req3.
5. credits=2, accept and credit_return in the same cycle → credits stays 2.
6. credits=4, credit_return pulse → overflow_err=1 next cycle and credits stays 4. overflow_err stays 1 until rst asserted low.
7. Assert rst low one cycle after a beat is accepted (pipeline holds it) → fifo_wrreq=0 immediately and stays 0 after release.

Source files
------------

// File: rtl/kanagawa_arb_pkg.sv
// kanagawa_arb_pkg
// Types and helpers shared by the cross-region write-side arbiter and the
// read-side demux/scheduler.
//   arb_state_t : arbiter lock state (IDLE, LOCKED)
//   id_width()  : source-tag width for a given requester count, usable in
//                 parameter defaults
package kanagawa_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // A single requester still needs a 1-bit tag so port widths never collapse to zero.
  function automatic int id_width(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/kanagawa_cross_region_arbiter_picker.sv
// KanagawaRoundRobinPicker
// Purely combinational round-robin search: the first asserted request at or
// after rr_ptr, wrapping around NUM_REQ.
// Ports:
//   req       in  NUM_REQ   request vector
//   rr_ptr    in  ID_WIDTH  highest-priority index for this search
//   grant     out NUM_REQ   one-hot grant (all zero when nothing requests)
//   grant_idx out ID_WIDTH  encoded index of the grant
//   grant_any out 1         some request was found
module KanagawaRoundRobinPicker
  import kanagawa_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                grant_any
);

  always_comb begin : search
    int cand;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = ID_WIDTH'(cand);
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kanagawa_cross_region_arbiter.sv
// kanagawa_cross_region_arbiter
// Shares the write port of one cross-region FIFO among NUM_REQ producers.
// Round-robin arbitration with packet locking; credits (initialised to DEPTH)
// replace the FIFO's full flag. Accepted beats are tagged with their source
// index and delayed WRITE_DELAY extra register stages before the FIFO.
// Ports:
//   clock          in  1                 rising-edge clock
//   rst            in  1                 asynchronous, active-low reset
//   req_valid      in  NUM_REQ           beat valid per requester
//   req_data       in  NUM_REQ*WIDTH     payload, requester i at [i*WIDTH +: WIDTH]
//   req_last       in  NUM_REQ           final beat of a packet
//   req_ready      out NUM_REQ           beat accepted when valid & ready
//   fifo_wrreq     out 1                 FIFO write strobe
//   fifo_data      out ID_WIDTH+WIDTH    {source id, payload}
//   credit_return  in  1                 one pulse per FIFO pop
//   credits        out CREDIT_WIDTH      free FIFO entries not yet claimed
//   overflow_err   out 1                 sticky: credit returned while full
module kanagawa_cross_region_arbiter
  import kanagawa_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 32,
  parameter int WRITE_DELAY  = 0,
  parameter int ID_WIDTH     = id_width(NUM_REQ),
  parameter int CREDIT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]    req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        fifo_wrreq,
  output logic [ID_WIDTH+WIDTH-1:0]   fifo_data,
  input  logic                        credit_return,
  output logic [CREDIT_WIDTH-1:0]     credits,
  output logic                        overflow_err
);

  localparam int BEAT_W = ID_WIDTH + WIDTH;
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(DEPTH);

  function automatic logic [ID_WIDTH-1:0] next_ptr(input logic [ID_WIDTH-1:0] idx);
    return (idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  arb_state_t          state, state_nxt;
  logic [ID_WIDTH-1:0] owner, rr_ptr, pick_idx, sel_idx;
  logic [NUM_REQ-1:0]  pick_grant;
  logic                pick_any, have_credit, accept, accept_last;
  logic [WIDTH-1:0]    sel_data;

  KanagawaRoundRobinPicker #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .grant_any (pick_any)
  );

  // Ready is gated by reset so nothing is accepted while rst is held low.
  always_comb begin
    have_credit = (credits != '0);
    sel_idx     = (state == LOCKED) ? owner : pick_idx;
    req_ready   = '0;
    if (rst && have_credit) begin
      if (state == LOCKED) req_ready[owner] = 1'b1;
      else if (pick_any)   req_ready = pick_grant;
    end
    accept      = |(req_ready & req_valid);
    accept_last = req_last[sel_idx];
    sel_data    = req_data[sel_idx*WIDTH +: WIDTH];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !accept_last) state_nxt = LOCKED;
      LOCKED:  if (accept && accept_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rr_ptr advances only on the packet's first beat, so it already points past
  // the owner when the lock is released.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && accept) begin
        owner  <= pick_idx;
        rr_ptr <= next_ptr(pick_idx);
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      credits      <= CREDIT_MAX;
      overflow_err <= 1'b0;
    end else begin
      case ({accept, credit_return})
        2'b10:   credits <= credits - 1'b1;
        2'b01: begin
          if (credits == CREDIT_MAX) overflow_err <= 1'b1;
          else                       credits      <= credits + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---- stage p0: accepted beat registered with its source tag ----
  logic              vld_p [0:WRITE_DELAY];
  logic [BEAT_W-1:0] beat_p[0:WRITE_DELAY];
  logic              vld_p0;
  logic [BEAT_W-1:0] beat_p0;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      vld_p0  <= 1'b0;
      beat_p0 <= '0;
    end else begin
      vld_p0 <= accept;
      if (accept) beat_p0 <= {sel_idx, sel_data};
    end
  end

  assign vld_p[0]  = vld_p0;
  assign beat_p[0] = beat_p0;

  // ---- stages p1..pWRITE_DELAY: plain delay towards the FIFO write port ----
  for (genvar g = 1; g <= WRITE_DELAY; g++) begin : gen_delay
    logic              vld_q;
    logic [BEAT_W-1:0] beat_q;
    always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
        vld_q  <= 1'b0;
        beat_q <= '0;
      end else begin
        vld_q  <= vld_p[g-1];
        beat_q <= beat_p[g-1];
      end
    end
    assign vld_p[g]  = vld_q;
    assign beat_p[g] = beat_q;
  end

  assign fifo_wrreq = vld_p[WRITE_DELAY];
  assign fifo_data  = beat_p[WRITE_DELAY];

endmodule

// File: tb/tb_kanagawa_cross_region_arbiter.sv
module tb_kanagawa_cross_region_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int WRITE_DELAY = 2;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        fifo_wrreq;
  logic [9:0]  fifo_data;
  logic        credit_return = 1'b0;
  logic [2:0]  credits;
  logic        overflow_err;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  kanagawa_cross_region_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .WRITE_DELAY (WRITE_DELAY)
  ) dut (
    .clock         (clock),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .fifo_wrreq    (fifo_wrreq),
    .fifo_data     (fifo_data),
    .credit_return (credit_return),
    .credits       (credits),
    .overflow_err  (overflow_err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; credit_return = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 4'hF; req_last = 4'hF;
    tick();
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready_in_reset: got %b expected 0000", req_ready); end
    req_valid = '0; req_last = '0;
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (credits !== 3'd4) begin n_fail++; $display("FAIL rst_credits: got %0d expected 4", credits); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b expected 0000", req_ready); end
    n_checks++; if (fifo_wrreq !== 1'b0) begin n_fail++; $display("FAIL rst_wrreq: got %b expected 0", fifo_wrreq); end
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b expected 0", overflow_err); end
    n_checks++; if (fifo_data !== 10'h000) begin n_fail++; $display("FAIL rst_data: got %h expected 000", fifo_data); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001; req_last = 4'b0001; req_data = 32'h0000_00A5;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0; req_last = '0;
    n_checks++; if (credits !== 3'd3) begin n_fail++; $display("FAIL single_credits: got %0d expected 3", credits); end
    n_checks++; if (fifo_wrreq !== 1'b0) begin n_fail++; $display("FAIL single_early_t1: got %b expected 0", fifo_wrreq); end
    tick();
    n_checks++; if (fifo_wrreq !== 1'b0) begin n_fail++; $display("FAIL single_early_t2: got %b expected 0", fifo_wrreq); end
    tick();
    n_checks++; if (fifo_wrreq !== 1'b1 || fifo_data !== 10'h0A5) begin n_fail++; $display("FAIL single_write_t3: got wr=%b data=%h expected wr=1 data=0a5", fifo_wrreq, fifo_data); end
    tick();
    n_checks++; if (fifo_wrreq !== 1'b0) begin n_fail++; $display("FAIL single_after_t4: got %b expected 0", fifo_wrreq); end
  endtask

  task automatic test_all_four();
    logic [9:0] exp_d;
    do_reset();
    req_valid = 4'hF; req_last = 4'hF; req_data = 32'h1312_1110;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (req_ready !== 4'(1 << k)) begin n_fail++; $display("FAIL rr_ready_%0d: got %b expected %b", k, req_ready, 4'(1 << k)); end
      tick();
      n_checks++; if (credits !== 3'(3 - k)) begin n_fail++; $display("FAIL rr_credits_%0d: got %0d expected %0d", k, credits, 3 - k); end
      if (k >= 2) begin
        exp_d = {2'(k - 2), 8'(16 + k - 2)};
        n_checks++; if (fifo_wrreq !== 1'b1 || fifo_data !== exp_d) begin n_fail++; $display("FAIL rr_out_%0d: got wr=%b data=%h expected wr=1 data=%h", k - 2, fifo_wrreq, fifo_data, exp_d); end
      end
    end
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_no_credit_ready: got %b expected 0000", req_ready); end
    for (int k = 2; k < 4; k++) begin
      tick();
      exp_d = {2'(k), 8'(16 + k)};
      n_checks++; if (fifo_wrreq !== 1'b1 || fifo_data !== exp_d) begin n_fail++; $display("FAIL rr_out_%0d: got wr=%b data=%h expected wr=1 data=%h", k, fifo_wrreq, fifo_data, exp_d); end
    end
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    n_checks++; if (credits !== 3'd1) begin n_fail++; $display("FAIL rr_return_credits: got %0d expected 1", credits); end
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_return_ready: got %b expected 0001", req_ready); end
    tick();
    n_checks++; if (credits !== 3'd0) begin n_fail++; $display("FAIL rr_reuse_credits: got %0d expected 0", credits); end
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_reuse_ready: got %b expected 0000", req_ready); end
    req_valid = '0; req_last = '0;
  endtask

  task automatic test_packet_lock();
    do_reset();
    req_valid = 4'b1110; req_data = 32'h3322_0000; credit_return = 1'b1;
    for (int b = 0; b < 3; b++) begin
      req_data[15:8] = 8'(b + 1);
      req_last = (b == 2) ? 4'b1110 : 4'b1100;
      #1;
      n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL lock_beat_%0d: got %b expected 0010", b, req_ready); end
      tick();
    end
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL lock_next_req2: got %b expected 0100", req_ready); end
    tick();
    #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL lock_next_req3: got %b expected 1000", req_ready); end
    tick();
    req_valid = '0; req_last = '0; credit_return = 1'b0;
    n_checks++; if (credits !== 3'd4) begin n_fail++; $display("FAIL lock_credits: got %0d expected 4", credits); end
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL lock_overflow: got %b expected 0", overflow_err); end
    n_checks++; if (fifo_wrreq !== 1'b1 || fifo_data !== 10'h103) begin n_fail++; $display("FAIL lock_out_beat3: got wr=%b data=%h expected wr=1 data=103", fifo_wrreq, fifo_data); end
  endtask

  task automatic test_credit_same_cycle();
    do_reset();
    req_valid = 4'b0001; req_last = 4'b0001; req_data = 32'h0000_0077;
    tick();
    tick();
    n_checks++; if (credits !== 3'd2) begin n_fail++; $display("FAIL same_setup_credits: got %0d expected 2", credits); end
    credit_return = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL same_ready: got %b expected 0001", req_ready); end
    tick();
    credit_return = 1'b0; req_valid = '0; req_last = '0;
    n_checks++; if (credits !== 3'd2) begin n_fail++; $display("FAIL same_cycle_credits: got %0d expected 2", credits); end
    tick();
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL same_overflow: got %b expected 0", overflow_err); end
  endtask

  task automatic test_overflow();
    do_reset();
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow_err); end
    n_checks++; if (credits !== 3'd4) begin n_fail++; $display("FAIL ovf_credits: got %0d expected 4", credits); end
    repeat (3) tick();
    n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow_err); end
    rst = 1'b0;
    #1;
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %b expected 0", overflow_err); end
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_after_release: got %b expected 0", overflow_err); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req_valid = 4'b1000; req_last = 4'b1000; req_data = 32'h3C00_0000;
    tick();
    req_valid = '0; req_last = '0;
    rst = 1'b0;
    #1;
    n_checks++; if (fifo_wrreq !== 1'b0) begin n_fail++; $display("FAIL mid_wrreq_in_reset: got %b expected 0", fifo_wrreq); end
    n_checks++; if (credits !== 3'd4) begin n_fail++; $display("FAIL mid_credits: got %0d expected 4", credits); end
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (fifo_wrreq !== 1'b0) begin n_fail++; $display("FAIL mid_wrreq_after_%0d: got %b expected 0", i, fifo_wrreq); end
    end
  endtask

  typedef struct {
    int         due;
    logic [9:0] val;
  } exp_t;

  task automatic test_random(input int n_cycles);
    int         m_owner, m_rr, m_cred, edge_n, w;
    bit         m_ovf, acc, lst, ret, exp_wr;
    logic [3:0] exp_rdy;
    logic [9:0] val;
    exp_t       q[$];
    exp_t       e;
    do_reset();
    m_owner = -1; m_rr = 0; m_cred = DEPTH; m_ovf = 0; edge_n = 0;
    for (int n = 0; n < n_cycles; n++) begin
      req_valid = 4'($urandom);
      req_last = 4'($urandom);
      req_data = $urandom;
      credit_return = (m_cred < DEPTH) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
      #1;
      // Expected winner from the arbitration rules.
      w = -1;
      exp_rdy = '0;
      if (m_cred > 0) begin
        if (m_owner >= 0) w = m_owner;
        else
          for (int k = 0; k < NUM_REQ; k++)
            if (w < 0 && req_valid[(m_rr + k) % NUM_REQ]) w = (m_rr + k) % NUM_REQ;
        if (w >= 0) exp_rdy[w] = 1'b1;
      end
      n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready_%0d: got %b expected %b", n, req_ready, exp_rdy); end
      acc = (w >= 0) && req_valid[w];
      lst = 1'b0;
      val = '0;
      if (acc) begin
        lst = req_last[w];
        val = {2'(w), req_data[w*8 +: 8]};
      end
      ret = credit_return;
      tick();
      edge_n++;
      if (acc && !ret) m_cred--;
      else if (!acc && ret) begin
        if (m_cred == DEPTH) m_ovf = 1;
        else m_cred++;
      end
      if (acc) begin
        if (m_owner < 0) begin
          m_rr = (w + 1) % NUM_REQ;
          if (!lst) m_owner = w;
        end else if (lst) m_owner = -1;
        e.due = edge_n + WRITE_DELAY;
        e.val = val;
        q.push_back(e);
      end
      exp_wr = (q.size() > 0) && (q[0].due == edge_n);
      n_checks++; if (fifo_wrreq !== exp_wr) begin n_fail++; $display("FAIL rand_wrreq_%0d: got %b expected %b", n, fifo_wrreq, exp_wr); end
      if (exp_wr) begin
        n_checks++; if (fifo_data !== q[0].val) begin n_fail++; $display("FAIL rand_data_%0d: got %h expected %h", n, fifo_data, q[0].val); end
        void'(q.pop_front());
      end
      n_checks++; if (credits !== 3'(m_cred)) begin n_fail++; $display("FAIL rand_credits_%0d: got %0d expected %0d", n, credits, m_cred); end
      n_checks++; if (overflow_err !== m_ovf) begin n_fail++; $display("FAIL rand_overflow_%0d: got %b expected %b", n, overflow_err, m_ovf); end
    end
    req_valid = '0; req_last = '0; credit_return = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_packet_lock();
    test_credit_same_cycle();
    test_overflow();
    test_reset_midflight();
    test_random(400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
